// File: rtl/sn74181_vector_recorder_pkg.sv
// Shared field widths, vector layout and FSM encoding for the SN74181 vector recorder.
// The bit order matches the checker's .mem files: {s,m,ci_n,a,b,f,co_n,x,y,aeqb}.
package sn74181_vector_recorder_pkg;

  localparam int S_W    = 4;
  localparam int M_W    = 1;
  localparam int CI_W   = 1;
  localparam int A_W    = 4;
  localparam int B_W    = 4;
  localparam int F_W    = 4;
  localparam int CO_W   = 1;
  localparam int X_W    = 1;
  localparam int Y_W    = 1;
  localparam int AEQB_W = 1;

  localparam int IDX_W = S_W + M_W + CI_W + A_W + B_W;
  localparam int RES_W = F_W + CO_W + X_W + Y_W + AEQB_W;
  localparam int VEC_W = IDX_W + RES_W;
  // One bit wider than the index so a full 16384-vector sweep is countable.
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } rec_state_t;

  function automatic logic [VEC_W-1:0] pack_vec(input logic [IDX_W-1:0] idx,
                                                input logic [RES_W-1:0] res);
    return {idx, res};
  endfunction

endpackage

// File: rtl/sn74181_settle_timer.sv
// Down-counter that holds the ALU inputs stable before its outputs are sampled.
// zero is high once the loaded count has been consumed.
module sn74181_settle_timer
  import sn74181_vector_recorder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(SETTLE_CYCLES - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sn74181_vector_recorder.sv
// Sweeps every {s,m,ci_n,a,b} combination into an SN74181, captures its outputs and
// streams each packed 22-bit result on a valid/ready interface for golden-file dumps.
//
//   state   | meaning
//   IDLE    | waiting for start
//   SETTLE  | ALU inputs held, settle timer running; outputs registered at timeout
//   CAPTURE | pack index and registered ALU outputs into vec_data
//   EMIT    | vec_valid high, waiting for vec_ready
//   DONE    | one-cycle done pulse after the final handshake
module sn74181_vector_recorder
  import sn74181_vector_recorder_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int VEC_LAST      = 16383
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [S_W-1:0]    alu_s,
  output logic              alu_m,
  output logic              alu_ci_n,
  output logic [A_W-1:0]    alu_a,
  output logic [B_W-1:0]    alu_b,
  input  logic [F_W-1:0]    alu_f,
  input  logic              alu_co_n,
  input  logic              alu_x,
  input  logic              alu_y,
  input  logic              alu_aeqb,
  output logic [VEC_W-1:0]  vec_data,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              vec_last,
  output logic [CNT_W-1:0]  vec_count
);

  rec_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [RES_W-1:0] res_q;
  logic [VEC_W-1:0] vec_data_q;
  logic             vec_last_q;
  logic [CNT_W-1:0] count_q;

  logic tmr_load, tmr_zero;
  logic accept, sample, capture, handshake;

  sn74181_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .dec (state_q == ST_SETTLE),
    .zero(tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          sample  = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (vec_ready) begin
          handshake = 1'b1;
          tmr_load  = !vec_last_q;
          state_d   = vec_last_q ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The final index is never incremented, so idx cannot wrap even at VEC_LAST=16383.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      res_q      <= '0;
      vec_data_q <= '0;
      vec_last_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (accept) begin
        idx_q   <= '0;
        count_q <= '0;
      end
      if (sample) res_q <= {alu_f, alu_co_n, alu_x, alu_y, alu_aeqb};
      if (capture) begin
        vec_data_q <= pack_vec(idx_q, res_q);
        vec_last_q <= (idx_q == IDX_W'(VEC_LAST));
      end
      if (handshake) begin
        count_q    <= count_q + CNT_W'(1);
        vec_last_q <= 1'b0;
        if (!vec_last_q) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign {alu_s, alu_m, alu_ci_n, alu_a, alu_b} = idx_q;

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE) || (state_q == ST_EMIT);
  assign done      = (state_q == ST_DONE);
  assign vec_valid = (state_q == ST_EMIT);
  assign vec_data  = vec_data_q;
  assign vec_last  = vec_last_q;
  assign vec_count = count_q;

endmodule

// File: tb/tb_sn74181_vector_recorder.sv
// Bench: three recorder instances (short sweep, mid sweep with stalls/reset, full sweep)
// each driving a behavioural SN74181; expected vectors are queued at start and popped per handshake.
module tb_sn74181_vector_recorder;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [3];
  logic        start [3];
  logic        rdy   [3];
  logic        busy  [3];
  logic        done  [3];
  logic        vv    [3];
  logic        vl    [3];
  logic [3:0]  s     [3];
  logic        m     [3];
  logic        ci    [3];
  logic [3:0]  a     [3];
  logic [3:0]  b     [3];
  logic [7:0]  res   [3];
  logic [21:0] vd    [3];
  logic [14:0] vc    [3];

  int n_vec = 0;
  int n_err = 0;

  // Active-high-data SN74181: returns {f[3:0], co_n, x, y, aeqb}.
  function automatic logic [7:0] alu181(input logic [13:0] v);
    logic [3:0] sel, op_a, op_b, p, g, f;
    logic       mode;
    logic [4:0] c;
    logic       x, y;
    sel  = v[13:10];
    mode = v[9];
    c[0] = ~v[8];
    op_a = v[7:4];
    op_b = v[3:0];
    for (int i = 0; i < 4; i++) begin
      p[i]   = op_a[i] | (op_b[i] & sel[0]) | (~op_b[i] & sel[1]);
      g[i]   = (op_a[i] & ~op_b[i] & sel[2]) | (op_a[i] & op_b[i] & sel[3]);
      f[i]   = ~(p[i] ^ g[i]) ^ ~(mode | c[i]);
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    x = ~&p;
    y = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    return {f, ~c[4], x, y, &f};
  endfunction

  assign res[0] = alu181({s[0], m[0], ci[0], a[0], b[0]});
  assign res[1] = alu181({s[1], m[1], ci[1], a[1], b[1]});
  assign res[2] = alu181({s[2], m[2], ci[2], a[2], b[2]});

  sn74181_vector_recorder #(.SETTLE_CYCLES(1), .VEC_LAST(3)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .alu_s(s[0]), .alu_m(m[0]), .alu_ci_n(ci[0]), .alu_a(a[0]), .alu_b(b[0]),
    .alu_f(res[0][7:4]), .alu_co_n(res[0][3]), .alu_x(res[0][2]), .alu_y(res[0][1]),
    .alu_aeqb(res[0][0]), .vec_data(vd[0]), .vec_valid(vv[0]), .vec_ready(rdy[0]),
    .vec_last(vl[0]), .vec_count(vc[0]));

  sn74181_vector_recorder #(.SETTLE_CYCLES(4), .VEC_LAST(150)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .alu_s(s[1]), .alu_m(m[1]), .alu_ci_n(ci[1]), .alu_a(a[1]), .alu_b(b[1]),
    .alu_f(res[1][7:4]), .alu_co_n(res[1][3]), .alu_x(res[1][2]), .alu_y(res[1][1]),
    .alu_aeqb(res[1][0]), .vec_data(vd[1]), .vec_valid(vv[1]), .vec_ready(rdy[1]),
    .vec_last(vl[1]), .vec_count(vc[1]));

  sn74181_vector_recorder #(.SETTLE_CYCLES(2), .VEC_LAST(16383)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .alu_s(s[2]), .alu_m(m[2]), .alu_ci_n(ci[2]), .alu_a(a[2]), .alu_b(b[2]),
    .alu_f(res[2][7:4]), .alu_co_n(res[2][3]), .alu_x(res[2][2]), .alu_y(res[2][1]),
    .alu_aeqb(res[2][0]), .vec_data(vd[2]), .vec_valid(vv[2]), .vec_ready(rdy[2]),
    .vec_last(vl[2]), .vec_count(vc[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] alu_in(input int k);
    return {s[k], m[k], ci[k], a[k], b[k]};
  endfunction

  task automatic check_reset_outputs(input int k, input string tag);
    check({tag, "_busy"},  32'(busy[k]), 32'd0);
    check({tag, "_done"},  32'(done[k]), 32'd0);
    check({tag, "_valid"}, 32'(vv[k]), 32'd0);
    check({tag, "_last"},  32'(vl[k]), 32'd0);
    check({tag, "_data"},  32'(vd[k]), 32'd0);
    check({tag, "_count"}, 32'(vc[k]), 32'd0);
    check({tag, "_alu"},   32'(alu_in(k)), 32'd0);
  endtask

  // Runs one sweep on instance k. pct = ready duty in percent; repulse pokes start
  // during vectors 5/6 and in DONE; rst_idx >= 0 aborts with a reset at that index.
  task automatic run_sweep(input int k, input int last, input int settle, input int pct,
                           input bit repulse, input int rst_idx);
    logic [21:0] q[$];
    logic [21:0] exp_v, held_d;
    logic [13:0] alu_prev, held_alu;
    logic        held_l;
    bit          stalled;
    int          edges, last_chg, budget, popped;
    for (int i = 0; i <= last; i++) q.push_back({14'(i), alu181(14'(i))});
    rdy[k]   = 1'b0;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    edges = 1;
    check("busy_after_start", 32'(busy[k]), 32'd1);
    while (!vv[k] && edges < settle + 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check("first_valid_latency", 32'(edges), 32'(settle + 2));
    budget   = (last + 1) * (settle + 2) * 4 + 100;
    stalled  = 1'b0;
    alu_prev = alu_in(k);
    last_chg = 1;
    popped   = 0;
    while (q.size() > 0 && budget > 0) begin
      budget--;
      start[k] = 1'b0;
      if (alu_in(k) != alu_prev) begin
        if (pct == 100) check("alu_period", 32'(edges - last_chg), 32'(settle + 2));
        alu_prev = alu_in(k);
        last_chg = edges;
      end
      if (stalled) begin
        check("stall_valid", 32'(vv[k]), 32'd1);
        check("stall_data",  32'(vd[k]), 32'(held_d));
        check("stall_last",  32'(vl[k]), 32'(held_l));
        check("stall_alu",   32'(alu_in(k)), 32'(held_alu));
      end
      if (vv[k] && rst_idx >= 0 && int'(vd[k][21:8]) == rst_idx) begin
        rst[k] = 1'b1;
        rdy[k] = 1'b0;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        check_reset_outputs(k, "midsweep_rst");
        return;
      end
      rdy[k]  = (int'($urandom_range(99)) < pct);
      stalled = 1'b0;
      if (vv[k]) begin
        if (rdy[k]) begin
          check("count_before_hs", 32'(vc[k]), 32'(popped));
          exp_v = q.pop_front();
          popped++;
          n_vec++;
          check("vec_data", 32'(vd[k]), 32'(exp_v));
          check("vec_last", 32'(vl[k]), 32'(q.size() == 0));
          if (repulse && (popped == 6 || popped == 7)) start[k] = 1'b1;
          if (exp_v[21:8] == 14'd9525) begin
            check("vec9525_fields", 32'(vd[k] & 22'b11111111111111_1111_1_0_0_1),
                  32'(22'b1001_0_1_0011_0101_1000_1_0_0_0));
          end
        end else begin
          stalled  = 1'b1;
          held_d   = vd[k];
          held_l   = vl[k];
          held_alu = alu_in(k);
        end
      end
      @(posedge clk); #1;
      edges++;
    end
    start[k] = 1'b0;
    check("sweep_timeout", 32'(budget > 0), 32'd1);
    check("done_pulse",    32'(done[k]), 32'd1);
    check("busy_in_done",  32'(busy[k]), 32'd0);
    check("final_count",   32'(vc[k]), 32'(last + 1));
    check("alu_hold_final", 32'(alu_in(k)), 32'(last));
    if (pct == 100) check("sweep_duration", 32'(edges), 32'((settle + 2) * (last + 1) + 1));
    if (repulse) start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check("done_one_cycle", 32'(done[k]), 32'd0);
    check("idle_after_done", 32'(busy[k]), 32'd0);
    @(posedge clk); #1;
    check("start_in_done_ignored", 32'(busy[k]), 32'd0);
    check("count_holds", 32'(vc[k]), 32'(last + 1));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b0;
      rdy[k]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset1");
    check_reset_outputs(2, "reset2");

    run_sweep(0, 3, 1, 100, 1'b0, -1);
    run_sweep(1, 150, 4, 30, 1'b0, 100);
    run_sweep(1, 150, 4, 30, 1'b1, -1);
    run_sweep(1, 150, 4, 100, 1'b0, -1);
    run_sweep(2, 16383, 2, 100, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
